alu_arbiter: RTL and testbench

Shares one `ALU` instance between two requesters using valid/ready handshakes and round-robin arbitration. The block registers the granted operands and the ALU result/flags, then holds the response until the owning requester accepts it. It sits between the slave's command decoders and the shared arithmetic datapath.

---
 rtl/alu_pkg.sv | 9 +
 rtl/ALU.sv | 26 ++
 rtl/alu_arbiter.sv | 70 +++++++
 tb/tb_alu_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, arbiter state and flag index definitions shared by the ALU and its arbiter
package alu_pkg;
   typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11} alu_op_t;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
endpackage

// File: rtl/ALU.sv
// ALU: combinational ADD/SUB/AND/OR with {N,Z,C,V} flags; C is the carry out (no-borrow on SUB)
module ALU
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   logic sub;
   logic [WIDTH:0] sum;
   always_comb begin
      sub = op == SUB;
      sum = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, sub};
      result = op == AND ? a & b : op == OR ? a | b : sum[WIDTH-1:0];
      flags = '0;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = result == '0;
      flags[FLAG_C] = !op[1] && sum[WIDTH];
      // signed overflow: ADD needs equal operand signs, SUB needs differing ones
      flags[FLAG_V] = !op[1] && ((a[WIDTH-1] ^ b[WIDTH-1]) == sub) && (result[WIDTH-1] != a[WIDTH-1]);
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [1:0]       op1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             busy
);
   arb_state_t state_q, state_d;
   logic owner_q, last_grant_q, gnt;
   logic [WIDTH-1:0] a_q, b_q, alu_result, rsp_result_q;
   logic [3:0] alu_flags, rsp_flags_q;
   alu_op_t op_q;
   ALU #(.WIDTH(WIDTH)) u_alu (
      .a(a_q),
      .b(b_q),
      .op(op_q),
      .result(alu_result),
      .flags(alu_flags)
   );
   always_comb begin
      gnt = &req_valid ? !last_grant_q : req_valid[1];
      req_ready = state_q == IDLE ? req_valid & (gnt ? 2'b10 : 2'b01) : 2'b00;
      rsp_valid = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      busy = state_q != IDLE;
      state_d = state_q == IDLE ? (|req_ready ? EXEC : IDLE) :
                state_q == EXEC ? RESP : (rsp_ready[owner_q] ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= ADD;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && |req_ready) begin
            owner_q      <= gnt;
            last_grant_q <= gnt;
            a_q          <= gnt ? a1 : a0;
            b_q          <= gnt ? b1 : b0;
            op_q         <= alu_op_t'(gnt ? op1 : op0);
         end
         if (state_q == EXEC) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
         end
      end
   end
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with WIDTH=4
module tb_alu_arbiter;
   typedef struct packed {
      logic [1:0] vld;
      logic [3:0] res;
      logic [3:0] flg;
   } rsp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] req_valid, req_ready, op0, op1, rsp_valid, rsp_ready;
   logic [3:0] a0, b0, a1, b1, rsp_result, rsp_flags;
   logic busy;
   rsp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;
   int last_g = 1;
   always #5 clk = ~clk;
   alu_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .a0(a0), .b0(b0), .op0(op0),
      .a1(a1), .b1(b1), .op1(op1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .busy(busy)
   );
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   // reference model built from signed/unsigned integer arithmetic
   function automatic rsp_t model(input int g, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int ai, bi, sa, sbv, s, t, r;
      logic [3:0] f;
      ai = int'(a);
      bi = int'(b);
      sa = ai > 7 ? ai - 16 : ai;
      sbv = bi > 7 ? bi - 16 : bi;
      s = 0;
      t = 0;
      case (op)
         2'd0: begin s = ai + bi; t = sa + sbv; end
         2'd1: begin s = ai + (15 - bi) + 1; t = sa - sbv; end
         2'd2: s = ai & bi;
         default: s = ai | bi;
      endcase
      r = s % 16;
      f[3] = r > 7;
      f[2] = r == 0;
      f[1] = op < 2 && s > 15;
      f[0] = op < 2 && (t < -8 || t > 7);
      model = {g == 1 ? 2'b10 : 2'b01, 4'(r), f};
   endfunction
   task automatic get_rsp();
      rsp_t e;
      int k = 0;
      while (rsp_valid === 2'b00 && k < 8) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_latency", 8'(k), 8'h0);
      chk("sb_nonempty", 8'(sb.size() != 0), 8'h1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("rsp_valid", 8'(rsp_valid), 8'(e.vld));
         chk("rsp_result", 8'(rsp_result), 8'(e.res));
         chk("rsp_flags", 8'(rsp_flags), 8'(e.flg));
      end
   endtask
   // called just after a negedge with requests driven; returns at the RESP negedge
   task automatic transact(input int g);
      #1 chk("req_ready_grant", 8'(req_ready), g == 1 ? 8'h2 : 8'h1);
      sb.push_back(model(g, g == 1 ? a1 : a0, g == 1 ? b1 : b0, g == 1 ? op1 : op0));
      last_g = g;
      @(posedge clk);
      @(negedge clk);
      chk("exec_busy", 8'(busy), 8'h1);
      chk("exec_rsp_valid", 8'(rsp_valid), 8'h0);
      chk("exec_req_ready", 8'(req_ready), 8'h0);
      @(negedge clk);
      get_rsp();
   endtask
   task automatic accept(input logic [1:0] rr);
      rsp_ready = rr;
      @(posedge clk);
      #1 rsp_ready = 2'b00;
      @(negedge clk);
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 8'(req_ready), 8'h0);
      chk({tag, "_rsp_valid"}, 8'(rsp_valid), 8'h0);
      chk({tag, "_result"}, 8'(rsp_result), 8'h0);
      chk({tag, "_flags"}, 8'(rsp_flags), 8'h0);
      chk({tag, "_busy"}, 8'(busy), 8'h0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      req_valid = 2'b00; rsp_ready = 2'b00;
      a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      // single ADD from requester 0
      a0 = 4'b1010; b0 = 4'b0010; op0 = 2'b00; req_valid = 2'b01;
      transact(0);
      chk("add_result", 8'(rsp_result), 8'h0c);
      chk("add_flags", 8'(rsp_flags), 8'h8);
      req_valid = 2'b00;
      accept(2'b01);
      chk("idle_busy", 8'(busy), 8'h0);
      // overflowing ADD from requester 1, rsp_ready already high on entry to RESP
      a1 = 4'b1111; b1 = 4'b1111; op1 = 2'b00; req_valid = 2'b10; rsp_ready = 2'b10;
      transact(1);
      chk("ovf_result", 8'(rsp_result), 8'h0e);
      chk("ovf_flags", 8'(rsp_flags), 8'ha);
      req_valid = 2'b00;
      @(negedge clk);
      chk("one_cycle_rsp_valid", 8'(rsp_valid), 8'h0);
      chk("one_cycle_busy", 8'(busy), 8'h0);
      rsp_ready = 2'b00;
      // contention: grants alternate starting with requester 0
      a0 = 4'b0100; b0 = 4'b0111; op0 = 2'b01;
      a1 = 4'b0100; b1 = 4'b0011; op1 = 2'b10;
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         chk("rr_order", 8'(1 - last_g), 8'(i % 2));
         transact(1 - last_g);
         if (i == 2) req_valid = 2'b00;
         accept(2'b11);
      end
      // back-pressure with only the non-owner's rsp_ready high
      a0 = 4'b1111; b0 = 4'b1111; op0 = 2'b11; req_valid = 2'b01;
      transact(0);
      req_valid = 2'b11; rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 8'(rsp_valid), 8'h1);
         chk("bp_result", 8'(rsp_result), 8'h0f);
         chk("bp_flags", 8'(rsp_flags), 8'h8);
         chk("bp_busy", 8'(busy), 8'h1);
         chk("bp_req_ready", 8'(req_ready), 8'h0);
      end
      accept(2'b01);
      transact(1);
      req_valid = 2'b00;
      accept(2'b10);
      // reset during EXEC
      a0 = 4'b0011; b0 = 4'b0100; op0 = 2'b00; req_valid = 2'b01;
      #1 chk("rst_exec_handshake", 8'(req_ready), 8'h1);
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      chk("rst_exec_busy_before", 8'(busy), 8'h1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rst_exec");
      rst = 1'b0;
      // reset during RESP
      req_valid = 2'b01;
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_resp_valid_before", 8'(rsp_valid), 8'h1);
      chk("rst_resp_result_before", 8'(rsp_result), 8'h07);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rst_resp");
      rst = 1'b0;
      last_g = 1;
      // first contention after reset goes to requester 0
      a0 = 4'b0100; b0 = 4'b0111; op0 = 2'b01; req_valid = 2'b11;
      transact(0);
      req_valid = 2'b00;
      accept(2'b01);
      chk("sb_drained", 8'(sb.size()), 8'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
